// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg : access sizes, FSM states and byte-enable base patterns      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [3:0] c_BE_BYTE = 4'b0001;
  localparam logic [3:0] c_BE_HALF = 4'b0011;
  localparam logic [3:0] c_BE_WORD = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// +----------------------------------------------------------------------+
// | lsu_if : single-outstanding request/grant/response data-memory port   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/load_extract.sv
// +----------------------------------------------------------------------+
// | load_extract : lane select, zero/sign extension and ARM word rotate   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic        arm,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rot;

  always_comb begin
    case (offset)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase

    w_half = offset[1] ? word[31:16] : word[15:0];

    // ARM unaligned LDR returns the aligned word rotated right by 8*offset
    case (offset)
      2'd0:    w_rot = word;
      2'd1:    w_rot = {word[7:0],  word[31:8]};
      2'd2:    w_rot = {word[15:0], word[31:16]};
      default: w_rot = {word[23:0], word[31:24]};
    endcase

    case (size)
      BYTE:    result = {{24{is_signed & w_byte[7]}}, w_byte};
      HALF:    result = {{16{is_signed & w_half[15]}}, w_half};
      default: result = arm ? w_rot : word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// +----------------------------------------------------------------------+
// | lsu : memory-stage load/store unit with stall and misalign detection  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        armM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  SizeM,
  input  logic        SignedM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  lsu_if.master       mem,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM
);

  localparam logic [1:0] c_ST_IDLE = IDLE;
  localparam logic [1:0] c_ST_REQ  = REQ;
  localparam logic [1:0] c_ST_WAIT = WAIT;
  localparam logic [1:0] c_ST_DONE = DONE;

  logic [1:0]  r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_offset;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_arm;
  logic [31:0] r_read_data;

  logic        w_access;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misaligned;
  logic        w_fault;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

  assign w_access     = MemReadM | MemWriteM;
  assign w_is_byte    = (SizeM == BYTE);
  assign w_is_half    = (SizeM == HALF);
  assign w_is_word    = ~w_is_byte & ~w_is_half;
  assign w_misaligned = (w_is_half & ALUResultM[0]) |
                        (w_is_word & (ALUResultM[1:0] != 2'b00));
  // Only RISC-V faults; ARM accesses are force-aligned or rotated instead
  assign w_fault      = (r_state == c_ST_IDLE) & w_access & ~armM & w_misaligned;

  always_comb begin
    w_be    = c_BE_WORD;
    w_wdata = WriteDataM;
    if (w_is_byte) begin
      w_be    = c_BE_BYTE << ALUResultM[1:0];
      w_wdata = {4{WriteDataM[7:0]}};
    end else if (w_is_half) begin
      w_be    = c_BE_HALF << {ALUResultM[1], 1'b0};
      w_wdata = {2{WriteDataM[15:0]}};
    end
  end

  load_extract u_load_extract (
    .word      (mem.mem_rdata),
    .offset    (r_offset),
    .size      (r_size),
    .is_signed (r_signed),
    .arm       (r_arm),
    .result    (w_load)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_offset    <= 2'd0;
      r_size      <= 2'd0;
      r_signed    <= 1'b0;
      r_arm       <= 1'b0;
      r_read_data <= 32'd0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_access && !w_fault) begin
            r_we     <= MemWriteM;
            r_addr   <= {ALUResultM[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_offset <= ALUResultM[1:0];
            r_size   <= SizeM;
            r_signed <= SignedM;
            r_arm    <= armM;
            r_state  <= c_ST_REQ;
          end
        end
        c_ST_REQ: begin
          if (mem.mem_gnt) begin
            r_state <= r_we ? c_ST_DONE : c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          if (mem.mem_rvalid) begin
            r_read_data <= w_load;
            r_state     <= c_ST_DONE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign mem.mem_req   = (r_state == c_ST_REQ);
  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_be    = r_be;
  assign mem.mem_wdata = r_wdata;

  assign StallM    = w_access & (((r_state == c_ST_IDLE) & ~w_fault) |
                                 (r_state == c_ST_REQ) | (r_state == c_ST_WAIT));
  assign ReadDataM = r_read_data;
  assign MisalignM = w_fault;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// +----------------------------------------------------------------------+
// | tb_lsu : randomized bench for lsu with a byte-array memory model      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lsu;

  logic        clk;
  logic        reset;
  logic        armM;
  logic        MemReadM;
  logic        MemWriteM;
  logic [1:0]  SizeM;
  logic        SignedM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        MisalignM;

  lsu_if mem ();

  lsu dut (
    .clk        (clk),
    .reset      (reset),
    .armM       (armM),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .SizeM      (SizeM),
    .SignedM    (SignedM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .mem        (mem.master),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .MisalignM  (MisalignM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  mem_bytes [1024];
  logic [31:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {mem_bytes[b + 10'd3], mem_bytes[b + 10'd2], mem_bytes[b + 10'd1], mem_bytes[b]};
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    for (int k = 0; k < 4; k++) mem_bytes[b + 10'(k)] = 8'(v >> (8 * k));
  endtask

  // One pipeline instruction: reference expectations, then cycle-by-cycle memory responder
  task automatic run_op(input logic arm, input logic rd, input logic wr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                        input int gdly, input int rdly);
    logic        acc, is_b, is_h, is_w, mis, granted, done;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, w, h;
    logic [9:0]  a, hb;
    int          off, stalls, reqs, waits, cyc;

    acc  = rd | wr;
    is_b = (size == 2'b00);
    is_h = (size == 2'b01);
    is_w = size[1];
    mis  = acc && !arm && ((is_h && addr[0]) || (is_w && addr[1:0] != 2'b00));
    a    = addr[9:0];
    hb   = {addr[9:1], 1'b0};
    off  = int'(addr[1:0]);

    if (is_b) begin
      exp_be = 4'(1 << off);
      exp_wd = {24'd0, wd[7:0]} * 32'h01010101;
      w      = {24'd0, mem_bytes[a]};
      exp_rd = (sgn && w[7]) ? (w | 32'hFFFFFF00) : w;
    end else if (is_h) begin
      exp_be = 4'(3 << (2 * int'(addr[1])));
      exp_wd = {16'd0, wd[15:0]} * 32'h00010001;
      h      = {16'd0, mem_bytes[hb + 10'd1], mem_bytes[hb]};
      exp_rd = (sgn && h[15]) ? (h | 32'hFFFF0000) : h;
    end else begin
      exp_be = 4'hF;
      exp_wd = wd;
      w      = mem_word(addr);
      exp_rd = arm ? ((w >> (8 * off)) | (w << (32 - 8 * off))) : w;
    end

    armM = arm; MemReadM = rd; MemWriteM = wr; SizeM = size; SignedM = sgn;
    ALUResultM = addr; WriteDataM = wd;
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;

    if (!acc || mis) begin
      @(negedge clk);
      check_eq("pass_stall", 32'(StallM), 32'd0);
      check_eq("pass_req", 32'(mem.mem_req), 32'd0);
      check_eq("misalign", 32'(MisalignM), 32'(mis));
      check_eq("pass_rdata_hold", ReadDataM, last_rd);
      @(posedge clk); #1;
      MemReadM = 1'b0; MemWriteM = 1'b0;
      @(negedge clk);
      check_eq("pass_req_after", 32'(mem.mem_req), 32'd0);
      @(posedge clk); #1;
      return;
    end

    stalls = 0; reqs = 0; waits = 0; cyc = 0; granted = 1'b0; done = 1'b0;
    while (!done && cyc < 64) begin
      mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
      mem.mem_rdata = $urandom;
      if (mem.mem_req) begin
        if (reqs == gdly) mem.mem_gnt = 1'b1;
      end else if (granted && rd) begin
        if (waits == rdly) begin
          mem.mem_rvalid = 1'b1;
          mem.mem_rdata  = mem_word(addr);
        end
        waits++;
      end
      @(negedge clk);
      if (StallM) stalls++;
      check_eq("busy_misalign", 32'(MisalignM), 32'd0);
      if (mem.mem_req) begin
        reqs++;
        check_eq("req_addr", mem.mem_addr, {addr[31:2], 2'b00});
        check_eq("req_be", 32'(mem.mem_be), 32'(exp_be));
        check_eq("req_we", 32'(mem.mem_we), 32'(wr));
        if (wr) check_eq("req_wdata", mem.mem_wdata, exp_wd);
      end
      if (!StallM) begin
        done = 1'b1;
        check_eq(rd ? "load_data" : "store_rdata_hold", ReadDataM, rd ? exp_rd : last_rd);
      end
      if (mem.mem_gnt) granted = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0;
    check_eq("op_completed", 32'(done), 32'd1);
    check_eq("stall_cycles", 32'(stalls), 32'(1 + gdly + 1 + (rd ? rdly + 1 : 0)));
    check_eq("req_cycles", 32'(reqs), 32'(gdly + 1));

    if (rd) last_rd = exp_rd;
    if (wr) begin
      if (is_b) mem_bytes[a] = wd[7:0];
      else if (is_h) begin
        mem_bytes[hb] = wd[7:0]; mem_bytes[hb + 10'd1] = wd[15:8];
      end else set_word(addr, wd);
    end
  endtask

  initial begin
    logic [31:0] r1, r2, r3;
    int kind;

    for (int i = 0; i < 1024; i++) begin
      r1 = $urandom;
      mem_bytes[i] = r1[7:0];
    end
    last_rd = 32'd0;
    reset = 1'b1;
    armM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; SizeM = 2'b00; SignedM = 1'b0;
    ALUResultM = 32'd0; WriteDataM = 32'd0;
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = 32'd0;

    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(mem.mem_req), 32'd0);
    check_eq("rst_we", 32'(mem.mem_we), 32'd0);
    check_eq("rst_addr", mem.mem_addr, 32'd0);
    check_eq("rst_be", 32'(mem.mem_be), 32'd0);
    check_eq("rst_wdata", mem.mem_wdata, 32'd0);
    check_eq("rst_rdata", ReadDataM, 32'd0);
    check_eq("rst_misalign", 32'(MisalignM), 32'd0);
    check_eq("rst_stall", 32'(StallM), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    set_word(32'h100, 32'hDEADBEEF);
    run_op(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 0, 0);        // lw
    run_op(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h203, 32'h000000A5, 2, 0); // sb
    set_word(32'h300, 32'h11802233);
    run_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h302, 32'd0, 0, 0);        // lb
    run_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h302, 32'd0, 1, 1);        // lbu
    run_op(1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h302, 32'd0, 0, 2);        // lh
    run_op(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 0, 0);        // misaligned lw
    set_word(32'h100, 32'h44332211);
    run_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'd0, 0, 0);        // ARM LDR rotate
    run_op(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h103, 32'hCAFEF00D, 1, 0); // ARM unaligned STR

    // Reset while a load is waiting for its response
    armM = 1'b0; MemReadM = 1'b1; MemWriteM = 1'b0; SizeM = 2'b10; SignedM = 1'b0;
    ALUResultM = 32'h140;
    @(posedge clk); #1;
    mem.mem_gnt = 1'b1;
    @(negedge clk);
    check_eq("rstw_req", 32'(mem.mem_req), 32'd1);
    @(posedge clk); #1;
    mem.mem_gnt = 1'b0;
    @(negedge clk);
    check_eq("rstw_wait_stall", 32'(StallM), 32'd1);
    reset = 1'b1; MemReadM = 1'b0;
    @(posedge clk); #1;
    check_eq("rstw_req_after", 32'(mem.mem_req), 32'd0);
    check_eq("rstw_stall_after", 32'(StallM), 32'd0);
    check_eq("rstw_rdata", ReadDataM, 32'd0);
    last_rd = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    set_word(32'h140, 32'h0BADF00D);
    run_op(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h140, 32'd0, 1, 1);

    for (int n = 0; n < 250; n++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      kind = int'($urandom_range(0, 4));
      run_op(r3[0], kind < 2, kind == 2 || kind == 3, r3[2:1], r3[3], r1, r2,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
